ecc_err_manager: RTL

Multi-channel ECC error manager and next-generation ECC controller. Aggregates SBE/MBE indications from NUM_CH independent ECC decoders. Keeps saturating per-channel SBE/MBE counters, per-channel SBE threshold detection and a sticky W1C interrupt status. Logs error events into a LOG_DEPTH-deep FIFO that software drains over APB. Sits between the per-bank ECC decoders and the safety interrupt controller.

---
 rtl/ecc_mgr_pkg.sv | 42 ++++
 rtl/ecc_err_log_fifo.sv | 49 ++++
 rtl/ecc_err_manager.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ecc_mgr_pkg.sv
// Shared definitions for the ECC error manager: register map, CTRL fields,
// error-log entry layout and event classification.
package ecc_mgr_pkg;

   localparam logic [7:0] REG_CTRL     = 8'h00;
   localparam logic [7:0] REG_IRQ_STAT = 8'h04;
   localparam logic [7:0] REG_LOG_STAT = 8'h08;
   localparam logic [7:0] REG_LOG_POP  = 8'h0C;
   localparam logic [7:0] REG_CNT_BASE = 8'h10;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_SBE_IE  = 1;
   localparam int CTRL_MBE_IE  = 2;
   localparam int CTRL_LOG_EN  = 3;
   localparam int CTRL_OVF_IE  = 4;
   localparam int CTRL_THR_LSB = 8;
   localparam logic [31:0] CTRL_MASK = 32'h0000_FF1F;

   localparam int STAT_MBE_LSB = 16;
   localparam int STAT_OVF_BIT = 31;
   localparam int LOG_POS_W    = 16;

   typedef enum logic [1:0] {
      EVT_NONE = 2'd0,
      EVT_SBE  = 2'd1,
      EVT_MBE  = 2'd2
   } evt_type_e;

   typedef struct packed {
      logic                 valid;
      logic [2:0]           ch;
      logic                 mbe;
      logic                 sbe;
      logic [LOG_POS_W-1:0] pos;
   } log_entry_t;

   // LOG_POP register image of a log entry
   function automatic logic [31:0] entry_to_word(input log_entry_t e);
      return {e.valid, 4'b0000, e.ch, 6'b000000, e.mbe, e.sbe, e.pos};
   endfunction

endpackage

// File: rtl/ecc_err_log_fifo.sv
// Synchronous error-log FIFO; a push into a full FIFO succeeds only when a
// pop happens in the same cycle, and a pop on empty is ignored.
module ecc_err_log_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 22
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [W-1:0]     mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
   logic [LVL_W-1:0] level_r;
   logic             do_push_s, do_pop_s;

   assign full      = (level_r == LVL_W'(DEPTH));
   assign empty     = (level_r == {LVL_W{1'b0}});
   assign level     = level_r;
   assign rdata     = mem_r[rd_ptr_r];
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);

   // Storage, pointers and fill level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {LVL_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         level_r <= level_r + LVL_W'(do_push_s) - LVL_W'(do_pop_s);
      end
   end

endmodule

// File: rtl/ecc_err_manager.sv
// Multi-channel ECC error manager: per-channel SBE/MBE counters, threshold
// and MBE status with W1C, interrupt generation and an APB-drained error log.
module ecc_err_manager
   import ecc_mgr_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = 16,
   parameter int POS_W     = 7,
   parameter int LOG_DEPTH = 8,
   parameter int ADDR_W    = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_CH-1:0]       ch_sbe,
   input  logic [NUM_CH-1:0]       ch_mbe,
   input  logic [NUM_CH*POS_W-1:0] ch_pos,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_W-1:0]       paddr,
   input  logic [31:0]             pwdata,
   output logic [31:0]             prdata,
   output logic                    pready,
   output logic                    pslverr,
   output logic                    irq,
   output logic                    mbe_fatal
);
   localparam int LVL_W = $clog2(LOG_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [31:0]       ctrl_r, stat_r;
   logic [15:0]       drop_cnt_r;
   logic              irq_r, mbe_fatal_r;
   logic [CNT_W-1:0]  sbe_cnt_r [NUM_CH];
   logic [CNT_W-1:0]  mbe_cnt_r [NUM_CH];

   logic              acc_s, wr_s, rd_s, mapped_s;
   logic              sel_ctrl_s, sel_stat_s, sel_lstat_s, sel_pop_s;
   logic [NUM_CH-1:0] sbe_sel_s, mbe_sel_s, sbe_clr_s, mbe_clr_s;
   logic [NUM_CH-1:0] sbe_q_s, mbe_q_s, sbe_inc_s, mbe_inc_s, thr_hit_s, pick_s;
   logic [7:0]        thr_s;
   evt_type_e         sel_type_s;
   logic [2:0]        sel_ch_s;
   logic [POS_W-1:0]  sel_pos_s;
   logic [3:0]        n_evt_s;
   logic              push_s, pop_req_s, drop_full_s;
   logic [4:0]        drop_inc_s;
   logic [16:0]       drop_sum_s;
   logic [31:0]       stat_set_s, w1c_s, cnt_rd_s, rdata_s;
   log_entry_t        wentry_s, head_s;
   logic              fifo_full_s, fifo_empty_s;
   logic [LVL_W-1:0]  fifo_level_s;

   assign acc_s     = psel & penable;
   assign wr_s      = acc_s & pwrite;
   assign rd_s      = acc_s & ~pwrite;
   assign thr_s     = ctrl_r[CTRL_THR_LSB +: 8];
   assign mbe_q_s   = ch_mbe & {NUM_CH{ctrl_r[CTRL_EN]}};
   assign sbe_q_s   = ch_sbe & ~ch_mbe & {NUM_CH{ctrl_r[CTRL_EN]}};
   assign sbe_clr_s = sbe_sel_s & {NUM_CH{wr_s}};
   assign mbe_clr_s = mbe_sel_s & {NUM_CH{wr_s}};

   // APB address decode
   always_comb begin
      sel_ctrl_s  = (paddr == ADDR_W'(REG_CTRL));
      sel_stat_s  = (paddr == ADDR_W'(REG_IRQ_STAT));
      sel_lstat_s = (paddr == ADDR_W'(REG_LOG_STAT));
      sel_pop_s   = (paddr == ADDR_W'(REG_LOG_POP));
      sbe_sel_s   = {NUM_CH{1'b0}};
      mbe_sel_s   = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         sbe_sel_s[i] = (paddr == ADDR_W'(int'(REG_CNT_BASE) + 8 * i));
         mbe_sel_s[i] = (paddr == ADDR_W'(int'(REG_CNT_BASE) + 8 * i + 4));
      end
      mapped_s = sel_ctrl_s | sel_stat_s | sel_lstat_s | sel_pop_s |
                 (|sbe_sel_s) | (|mbe_sel_s);
   end

   // Counter increments, threshold hits and log arbitration (MBE first, then lowest channel)
   always_comb begin
      sel_ch_s  = 3'd0;
      sel_pos_s = {POS_W{1'b0}};
      pick_s    = (|mbe_q_s) ? (mbe_q_s & (~mbe_q_s + NUM_CH'(1)))
                             : (sbe_q_s & (~sbe_q_s + NUM_CH'(1)));
      n_evt_s   = 4'(unsigned'($countones({sbe_q_s, mbe_q_s})));
      for (int i = 0; i < NUM_CH; i++) begin
         sbe_inc_s[i] = sbe_q_s[i] & ~sbe_clr_s[i] & (sbe_cnt_r[i] != CNT_MAX);
         mbe_inc_s[i] = mbe_q_s[i] & ~mbe_clr_s[i] & (mbe_cnt_r[i] != CNT_MAX);
         thr_hit_s[i] = sbe_inc_s[i] & (thr_s != 8'd0) &
                        ((sbe_cnt_r[i] + CNT_W'(1)) == CNT_W'(thr_s));
         sel_ch_s  = sel_ch_s  | (pick_s[i] ? 3'(i) : 3'd0);
         sel_pos_s = sel_pos_s | (pick_s[i] ? ch_pos[i*POS_W +: POS_W] : {POS_W{1'b0}});
      end
      sel_type_s = (|mbe_q_s) ? EVT_MBE : ((|sbe_q_s) ? EVT_SBE : EVT_NONE);
      wentry_s.valid = 1'b1;
      wentry_s.ch    = sel_ch_s;
      wentry_s.mbe   = (sel_type_s == EVT_MBE);
      wentry_s.sbe   = (sel_type_s == EVT_SBE);
      wentry_s.pos   = LOG_POS_W'(sel_pos_s);
   end

   assign push_s      = ctrl_r[CTRL_LOG_EN] & (sel_type_s != EVT_NONE);
   assign pop_req_s   = rd_s & sel_pop_s;
   assign drop_full_s = push_s & fifo_full_s & ~pop_req_s;
   assign drop_inc_s  = push_s ? (5'(n_evt_s) - 5'd1 + 5'(drop_full_s)) : 5'd0;
   assign drop_sum_s  = 17'(drop_cnt_r) + 17'(drop_inc_s);

   // Status set sources and write-one-to-clear mask
   always_comb begin
      stat_set_s                          = 32'h0000_0000;
      stat_set_s[NUM_CH-1:0]              = thr_hit_s;
      stat_set_s[STAT_MBE_LSB +: NUM_CH]  = mbe_q_s;
      stat_set_s[STAT_OVF_BIT]            = drop_full_s;
      w1c_s = (wr_s & sel_stat_s) ? pwdata : 32'h0000_0000;
   end

   // Read data mux
   always_comb begin
      cnt_rd_s = 32'h0000_0000;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_rd_s = cnt_rd_s | (sbe_sel_s[i] ? 32'(sbe_cnt_r[i]) : 32'h0000_0000)
                             | (mbe_sel_s[i] ? 32'(mbe_cnt_r[i]) : 32'h0000_0000);
      end
      if (!rd_s) begin
         rdata_s = 32'h0000_0000;
      end else if (sel_ctrl_s) begin
         rdata_s = ctrl_r;
      end else if (sel_stat_s) begin
         rdata_s = stat_r;
      end else if (sel_lstat_s) begin
         rdata_s = {drop_cnt_r, 6'b000000, fifo_full_s, fifo_empty_s, 2'b00, 6'(fifo_level_s)};
      end else if (sel_pop_s) begin
         rdata_s = fifo_empty_s ? 32'h0000_0000 : entry_to_word(head_s);
      end else begin
         rdata_s = cnt_rd_s;
      end
   end

   // Per-channel saturating counters; a clear write beats a same-cycle increment
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            sbe_cnt_r[i] <= {CNT_W{1'b0}};
            mbe_cnt_r[i] <= {CNT_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (sbe_clr_s[i])      sbe_cnt_r[i] <= {CNT_W{1'b0}};
            else if (sbe_inc_s[i]) sbe_cnt_r[i] <= sbe_cnt_r[i] + CNT_W'(1);
            if (mbe_clr_s[i])      mbe_cnt_r[i] <= {CNT_W{1'b0}};
            else if (mbe_inc_s[i]) mbe_cnt_r[i] <= mbe_cnt_r[i] + CNT_W'(1);
         end
      end
   end

   // Control, status, drop counter and registered interrupt outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_r      <= 32'h0000_0000;
         stat_r      <= 32'h0000_0000;
         drop_cnt_r  <= 16'h0000;
         irq_r       <= 1'b0;
         mbe_fatal_r <= 1'b0;
      end else begin
         if (wr_s & sel_ctrl_s) ctrl_r <= pwdata & CTRL_MASK;
         stat_r      <= (stat_r & ~w1c_s) | stat_set_s;
         drop_cnt_r  <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
         irq_r       <= ((|stat_r[NUM_CH-1:0]) & ctrl_r[CTRL_SBE_IE]) |
                        ((|stat_r[STAT_MBE_LSB +: NUM_CH]) & ctrl_r[CTRL_MBE_IE]) |
                        (stat_r[STAT_OVF_BIT] & ctrl_r[CTRL_OVF_IE]);
         mbe_fatal_r <= |mbe_q_s;
      end
   end

   ecc_err_log_fifo #(
      .DEPTH (LOG_DEPTH),
      .W     ($bits(log_entry_t))
   ) u_log_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_s),
      .pop     (pop_req_s),
      .wdata   (wentry_s),
      .rdata   (head_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .level   (fifo_level_s)
   );

   assign prdata    = rdata_s;
   assign pready    = acc_s;
   assign pslverr   = acc_s & ~mapped_s;
   assign irq       = irq_r;
   assign mbe_fatal = mbe_fatal_r;

endmodule
